// File: rtl/instruction_rom_loadable_if.sv
// Fetch and program-load signals of the loadable instruction ROM.
// The master side is the CPU / byte source, the slave side is the ROM.
interface instruction_rom_loadable_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 8
);
  // CPU fetch port
  logic [15:0]           iAddress;
  logic                  iReadEnable;
  logic [DATA_WIDTH-1:0] oInstruction;

  // Byte-stream program-load port
  logic                  iLoadStart;
  logic                  iLoadEnd;
  logic [7:0]            iLoadByte;
  logic                  iLoadValid;
  logic                  oLoadReady;
  logic                  oBusy;
  logic [ADDR_WIDTH:0]   oWordCount;
  logic                  oLoadError;

  modport master (
    output iAddress, iReadEnable, iLoadStart, iLoadEnd, iLoadByte, iLoadValid,
    input  oInstruction, oLoadReady, oBusy, oWordCount, oLoadError
  );

  modport slave (
    input  iAddress, iReadEnable, iLoadStart, iLoadEnd, iLoadByte, iLoadValid,
    output oInstruction, oLoadReady, oBusy, oWordCount, oLoadError
  );
endinterface

// File: rtl/instruction_rom_loadable.sv
// Synchronous instruction memory with a registered fetch port and a
// little-endian byte-stream load port. Unwritten words read DEFAULT_WORD.
module instruction_rom_loadable #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  instruction_rom_loadable_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BPW   = (DATA_WIDTH + 7) / 8;
  localparam int IDX_W = 2;               // BPW is at most 4
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      word_count_q, word_count_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  end_pend_q, end_pend_d;
  logic                  load_error_q, load_error_d;
  logic [DEPTH-1:0]      written_q, written_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic                  full;
  logic                  busy;
  logic                  load_ready;
  logic                  accept;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] byte_shift;

  // The word count doubles as the write pointer; it never wraps because
  // no byte is accepted once it reaches DEPTH.
  assign full       = (word_count_q == CNT_W'(DEPTH));
  assign busy       = (state_q != S_IDLE);
  assign load_ready = (state_q == S_COLLECT) && !full;
  // A start pulse restarts the load, so a byte offered with it is not taken.
  assign accept     = load_ready && bus.iLoadValid && !bus.iLoadStart;
  assign wr_addr    = word_count_q[ADDR_WIDTH-1:0];
  assign rd_addr    = bus.iAddress[ADDR_WIDTH-1:0];
  assign in_range   = ((bus.iAddress >> ADDR_WIDTH) == 16'd0);

  // Place the incoming byte at lane byte_idx; lanes above DATA_WIDTH fall off.
  assign byte_mask  = DATA_WIDTH'(8'hFF) << {byte_idx_q, 3'b000};
  assign byte_shift = DATA_WIDTH'(bus.iLoadByte) << {byte_idx_q, 3'b000};

  // Load state machine: next state, assembly register, bitmap and flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d      = state_q;
    word_count_d = word_count_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    end_pend_d   = end_pend_q;
    load_error_d = load_error_q;
    written_d    = written_q;
    mem_we       = 1'b0;

    if (bus.iLoadStart) begin
      // Restart from any state; a pending commit is dropped.
      written_d    = '0;
      word_count_d = '0;
      byte_idx_d   = '0;
      asm_d        = '0;
      end_pend_d   = 1'b0;
      load_error_d = 1'b0;
      state_d      = S_COLLECT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A lone end pulse is ignored.
        end

        S_COLLECT: begin
          if (accept) begin
            asm_d = (asm_q & ~byte_mask) | byte_shift;
            if (byte_idx_q == IDX_W'(BPW - 1)) begin
              // Word complete: commit it, then honour an end seen now.
              byte_idx_d = '0;
              end_pend_d = bus.iLoadEnd;
              state_d    = S_COMMIT;
            end else if (bus.iLoadEnd) begin
              // End lands mid-word: the partial word is thrown away.
              byte_idx_d   = '0;
              load_error_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end else begin
            if (bus.iLoadValid && full) begin
              load_error_d = 1'b1;
            end
            if (bus.iLoadEnd) begin
              if (byte_idx_q != '0) begin
                load_error_d = 1'b1;
              end
              byte_idx_d = '0;
              state_d    = S_IDLE;
            end
          end
        end

        S_COMMIT: begin
          if (!full) begin
            mem_we             = 1'b1;
            written_d[wr_addr] = 1'b1;
            word_count_d       = word_count_q + 1'b1;
          end
          end_pend_d = 1'b0;
          state_d    = (end_pend_q || bus.iLoadEnd) ? S_IDLE : S_COLLECT;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Fetch path: refresh the output word only on a read strobe.
  always_comb begin
    instr_d = instr_q;
    if (bus.iReadEnable) begin
      if (busy || !in_range || !written_q[rd_addr]) begin
        instr_d = DEFAULT_WORD;
      end else begin
        instr_d = mem[rd_addr];
      end
    end
  end

  // State and control registers with synchronous active-high reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (Reset) begin
      state_q      <= S_IDLE;
      word_count_q <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      end_pend_q   <= 1'b0;
      load_error_q <= 1'b0;
      written_q    <= '0;
      instr_q      <= DEFAULT_WORD;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      end_pend_q   <= end_pend_d;
      load_error_q <= load_error_d;
      written_q    <= written_d;
      instr_q      <= instr_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge Clock) begin
    // NOTE: the array itself is not reset; the written bitmap masks stale
    // contents, which keeps the array mappable to block RAM.
    if (mem_we) begin
      mem[wr_addr] <= asm_q;
    end
  end

  assign bus.oInstruction = instr_q;
  assign bus.oLoadReady   = load_ready;
  assign bus.oBusy        = busy;
  assign bus.oWordCount   = word_count_q;
  assign bus.oLoadError   = load_error_q;

endmodule

// File: tb/tb_instruction_rom_loadable.sv
// Directed bench for instruction_rom_loadable: a default-size instance and
// a 4-word instance for the memory-full case.
module tb_instruction_rom_loadable;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  instruction_rom_loadable_if #(.DATA_WIDTH(28), .ADDR_WIDTH(8)) bus ();
  instruction_rom_loadable_if #(.DATA_WIDTH(28), .ADDR_WIDTH(2)) bus_s ();

  instruction_rom_loadable #(.DATA_WIDTH(28), .ADDR_WIDTH(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  instruction_rom_loadable #(.DATA_WIDTH(28), .ADDR_WIDTH(2)) dut_s (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_s)
  );

  typedef struct {
    logic [15:0] addr;
    logic [27:0] exp;
  } fetch_vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.iLoadStart = 1'b1;
    tick();
    bus.iLoadStart = 1'b0;
  endtask

  task automatic pulse_end();
    bus.iLoadEnd = 1'b1;
    tick();
    bus.iLoadEnd = 1'b0;
  endtask

  // Offer one byte until accepted (bounded); optionally raise end with it.
  task automatic send_byte(input logic [7:0] b, input bit with_end);
    bit done = 1'b0;
    bus.iLoadByte  = b;
    bus.iLoadValid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done         = bus.oLoadReady;
      bus.iLoadEnd = with_end && bus.oLoadReady;
      tick();
    end
    bus.iLoadValid = 1'b0;
    bus.iLoadEnd   = 1'b0;
    check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic send_byte_s(input logic [7:0] b);
    bit done = 1'b0;
    bus_s.iLoadByte  = b;
    bus_s.iLoadValid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus_s.oLoadReady;
      tick();
    end
    bus_s.iLoadValid = 1'b0;
    check("send_accept_s", 32'(done), 32'd1);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [27:0] exp, input string name);
    bus.iAddress    = a;
    bus.iReadEnable = 1'b1;
    tick();
    bus.iReadEnable = 1'b0;
    check(name, 32'(bus.oInstruction), 32'(exp));
  endtask

  fetch_vec_t  reset_vecs [3];
  fetch_vec_t  load_vecs  [5];
  logic [27:0] small_exp  [4];

  initial begin
    reset_vecs[0] = '{16'd0,   28'h0000000};
    reset_vecs[1] = '{16'd5,   28'h0000000};
    reset_vecs[2] = '{16'd300, 28'h0000000};

    load_vecs[0]  = '{16'd0,   28'h4332211};
    load_vecs[1]  = '{16'd1,   28'h8776655};
    load_vecs[2]  = '{16'd2,   28'h0000000};
    load_vecs[3]  = '{16'd256, 28'h0000000};  // aliases word 0 in the low bits
    load_vecs[4]  = '{16'd300, 28'h0000000};

    small_exp[0]  = 28'h5C0B0A0;
    small_exp[1]  = 28'h5C1B1A1;
    small_exp[2]  = 28'h5C2B2A2;
    small_exp[3]  = 28'h5C3B3A3;

    bus.iAddress = '0;   bus.iReadEnable = 0; bus.iLoadStart = 0;
    bus.iLoadEnd = 0;    bus.iLoadByte   = '0; bus.iLoadValid = 0;
    bus_s.iAddress = '0; bus_s.iReadEnable = 0; bus_s.iLoadStart = 0;
    bus_s.iLoadEnd = 0;  bus_s.iLoadByte   = '0; bus_s.iLoadValid = 0;

    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_instr", 32'(bus.oInstruction), 32'h0);
    check("rst_busy",  32'(bus.oBusy),        32'd0);
    check("rst_ready", 32'(bus.oLoadReady),   32'd0);
    check("rst_count", 32'(bus.oWordCount),   32'd0);
    check("rst_error", 32'(bus.oLoadError),   32'd0);
    for (int i = 0; i < 3; i++)
      fetch(reset_vecs[i].addr, reset_vecs[i].exp, $sformatf("fetch_rst[%0d]", i));

    // Two-word load; the byte after the first word is held across COMMIT.
    pulse_start();
    check("load_busy", 32'(bus.oBusy), 32'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'hF4, 0);
    check("commit_ready", 32'(bus.oLoadReady), 32'd0);
    check("commit_busy",  32'(bus.oBusy),      32'd1);
    send_byte(8'h55, 0);
    check("count_after_w0", 32'(bus.oWordCount), 32'd1);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    send_byte(8'h08, 0);
    pulse_end();                      // end arrives during COMMIT
    check("load2_count", 32'(bus.oWordCount), 32'd2);
    check("load2_error", 32'(bus.oLoadError), 32'd0);
    check("load2_busy",  32'(bus.oBusy),      32'd0);
    for (int i = 0; i < 5; i++)
      fetch(load_vecs[i].addr, load_vecs[i].exp, $sformatf("fetch_load[%0d]", i));

    // Output holds when the strobe is low.
    fetch(16'd0, 28'h4332211, "hold_prep");
    bus.iAddress = 16'd1;
    tick();
    check("hold_no_strobe", 32'(bus.oInstruction), 32'h4332211);

    // Partial word at end: error, one word kept; fetch while busy is masked.
    pulse_start();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    tick();                           // COMMIT of word 0
    fetch(16'd0, 28'h0000000, "fetch_while_busy");
    check("busy_during_fetch", 32'(bus.oBusy), 32'd1);
    send_byte(8'hEE, 0);
    send_byte(8'hFF, 0);
    pulse_end();
    check("partial_count", 32'(bus.oWordCount), 32'd1);
    check("partial_error", 32'(bus.oLoadError), 32'd1);
    fetch(16'd0, 28'hDCCBBAA, "partial_w0");
    fetch(16'd1, 28'h0000000, "partial_w1");
    pulse_start();
    check("start_clears_error", 32'(bus.oLoadError), 32'd0);
    pulse_end();
    check("empty_end_error", 32'(bus.oLoadError), 32'd0);
    check("empty_end_count", 32'(bus.oWordCount), 32'd0);

    // Lone end ignored; start+end together starts a load; restart mid-load.
    pulse_end();
    check("lone_end_busy", 32'(bus.oBusy), 32'd0);
    bus.iLoadStart = 1'b1;
    bus.iLoadEnd   = 1'b1;
    tick();
    bus.iLoadStart = 1'b0;
    bus.iLoadEnd   = 1'b0;
    check("start_wins_busy", 32'(bus.oBusy), 32'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'hF4, 0);
    tick();
    check("pre_restart_count", 32'(bus.oWordCount), 32'd1);
    send_byte(8'h99, 0);
    pulse_start();
    check("restart_count", 32'(bus.oWordCount), 32'd0);
    check("restart_busy",  32'(bus.oBusy),      32'd1);
    pulse_end();
    check("restart_end_error", 32'(bus.oLoadError), 32'd0);
    fetch(16'd0, 28'h0000000, "restart_w0_default");

    // Reset mid-load after one committed word.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    tick();
    send_byte(8'h05, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_busy",  32'(bus.oBusy),      32'd0);
    check("midrst_count", 32'(bus.oWordCount), 32'd0);
    check("midrst_ready", 32'(bus.oLoadReady), 32'd0);
    fetch(16'd0, 28'h0000000, "midrst_w0_default");

    // End together with the byte that completes a word: word still commits.
    pulse_start();
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 1);
    tick();                           // COMMIT, then IDLE
    check("end_accept_busy",  32'(bus.oBusy),      32'd0);
    check("end_accept_count", 32'(bus.oWordCount), 32'd1);
    check("end_accept_error", 32'(bus.oLoadError), 32'd0);
    fetch(16'd0, 28'h2345678, "end_accept_w0");

    // Four-word instance: overfill, then check saturation and contents.
    bus_s.iLoadStart = 1'b1;
    tick();
    bus_s.iLoadStart = 1'b0;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        send_byte_s((k == 3) ? 8'h05 : 8'(8'hA0 + 16 * k + w));
    tick();                           // fourth COMMIT
    check("full_ready", 32'(bus_s.oLoadReady), 32'd0);
    check("full_count", 32'(bus_s.oWordCount), 32'd4);
    check("full_error_before", 32'(bus_s.oLoadError), 32'd0);
    bus_s.iLoadByte  = 8'hEE;
    bus_s.iLoadValid = 1'b1;
    repeat (52) tick();               // remaining 13 words' worth of bytes
    bus_s.iLoadValid = 1'b0;
    check("overfill_error", 32'(bus_s.oLoadError), 32'd1);
    check("overfill_count", 32'(bus_s.oWordCount), 32'd4);
    bus_s.iLoadEnd = 1'b1;
    tick();
    bus_s.iLoadEnd = 1'b0;
    check("small_idle", 32'(bus_s.oBusy), 32'd0);
    for (int w = 0; w < 5; w++) begin
      bus_s.iAddress    = 16'(w);
      bus_s.iReadEnable = 1'b1;
      tick();
      bus_s.iReadEnable = 1'b0;
      check($sformatf("small_w[%0d]", w), 32'(bus_s.oInstruction),
            (w < 4) ? 32'(small_exp[w]) : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
